// File: rtl/multdiv_pkg.sv
// Shared constants, FSM state type and radix-4 Booth digit encoding for the multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned MULT_ITERS = WIDTH / 2;
    localparam int unsigned DIV_ITERS  = WIDTH;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMult = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        BoothZero,
        BoothP1,
        BoothP2,
        BoothM1,
        BoothM2
    } booth_e;

    // Window is {q[i+1], q[i], q[i-1]} of the multiplier.
    function automatic booth_e booth_decode(input logic [2:0] win);
        booth_e d;
        case (win)
            3'b001, 3'b010: d = BoothP1;
            3'b011:         d = BoothP2;
            3'b100:         d = BoothM2;
            3'b101, 3'b110: d = BoothM1;
            default:        d = BoothZero;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multdiv_if.sv
// Start/operand/result bundle between the execute stage (master) and the multiply/divide unit (slave).
interface multdiv_if;
    import multdiv_pkg::*;

    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );

endinterface

// File: rtl/multdiv_booth_sel.sv
// Radix-4 Booth addend selector: 3-bit multiplier window -> 0, +/-M or +/-2M, sign-extended to WIDTH+2.
module multdiv_booth_sel
    import multdiv_pkg::*;
(
    input  logic [2:0]       i_window,
    input  logic [WIDTH-1:0] i_mcand,
    output logic [WIDTH+1:0] o_addend
);

    booth_e           w_digit;
    logic [WIDTH+1:0] w_m1;
    logic [WIDTH+1:0] w_m2;

    assign w_digit = booth_decode(i_window);
    assign w_m1    = {{2{i_mcand[WIDTH-1]}}, i_mcand};
    assign w_m2    = {w_m1[WIDTH:0], 1'b0};

    always_comb begin
        o_addend = '0;
        case (w_digit)
            BoothP1: o_addend = w_m1;
            BoothP2: o_addend = w_m2;
            BoothM1: o_addend = -w_m1;
            BoothM2: o_addend = -w_m2;
            default: o_addend = '0;
        endcase
    end

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (radix-4 Booth) / divide (non-restoring) unit with a one-cycle ready pulse.
module multdiv_unit
    import multdiv_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    multdiv_if.slave mdu
);

    localparam logic [4:0]       MultLast = 5'(MULT_ITERS - 1);
    localparam logic [4:0]       DivLast  = 5'(DIV_ITERS - 1);
    localparam logic [WIDTH-1:0] MinInt   = {1'b1, {(WIDTH - 1){1'b0}}};

    state_e             r_state;
    state_e             w_state_next;
    logic [4:0]         r_cnt;
    logic               r_is_div;
    logic [2*WIDTH+1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_neg;
    logic               r_dz;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_rdy;

    logic               w_start_mult;
    logic               w_start_div;
    logic [WIDTH+1:0]   w_addend;
    logic [WIDTH+1:0]   w_sum;
    logic [2*WIDTH+1:0] w_prod_nx;
    logic [WIDTH:0]     w_prod_hi;
    logic               w_mult_ovf;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_nx;
    logic [WIDTH-1:0]   w_quo_fix;

    assign w_start_mult = mdu.ctrl_MULT;
    assign w_start_div  = mdu.ctrl_DIV & ~mdu.ctrl_MULT;

    multdiv_booth_sel u_booth_sel (
        .i_window (r_prod[2:0]),
        .i_mcand  (r_mcand),
        .o_addend (w_addend)
    );

    // Add into the top WIDTH+1 bits (sign-extended), then arithmetic-shift the whole register by two.
    assign w_sum      = {r_prod[2*WIDTH+1], r_prod[2*WIDTH+1:WIDTH+1]} + w_addend;
    assign w_prod_nx  = {w_sum[WIDTH+1], w_sum, r_prod[WIDTH:2]};
    assign w_prod_hi  = r_prod[2*WIDTH:WIDTH];
    assign w_mult_ovf = ~((&w_prod_hi) | ~(|w_prod_hi));

    // |MinInt| wraps to itself, which is correct when read as unsigned.
    assign w_abs_a   = mdu.data_operandA[WIDTH-1] ? -mdu.data_operandA : mdu.data_operandA;
    assign w_abs_b   = mdu.data_operandB[WIDTH-1] ? -mdu.data_operandB : mdu.data_operandB;
    assign w_rem_sh  = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_rem_nx  = r_rem[WIDTH] ? w_rem_sh + {1'b0, r_dvsr} : w_rem_sh - {1'b0, r_dvsr};
    assign w_quo_fix = r_neg ? -r_quo : r_quo;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A start pulse restarts from any state, aborting whatever was in flight.
    always_comb begin
        w_state_next = r_state;
        if (w_start_mult) begin
            w_state_next = StMult;
        end else if (w_start_div) begin
            w_state_next = StDiv;
        end else begin
            case (r_state)
                StMult:  if (r_cnt == MultLast) w_state_next = StDone;
                StDiv:   if (r_cnt == DivLast) w_state_next = StDone;
                StDone:  w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_start_mult) begin
                r_cnt    <= '0;
                r_is_div <= 1'b0;
                r_mcand  <= mdu.data_operandA;
                r_prod   <= {{(WIDTH + 1){1'b0}}, mdu.data_operandB, 1'b0};
            end else if (w_start_div) begin
                r_cnt    <= '0;
                r_is_div <= 1'b1;
                r_rem    <= '0;
                r_quo    <= w_abs_a;
                r_dvsr   <= w_abs_b;
                r_neg    <= mdu.data_operandA[WIDTH-1] ^ mdu.data_operandB[WIDTH-1];
                r_dz     <= (mdu.data_operandB == '0);
                r_ovf    <= (mdu.data_operandA == MinInt) && (mdu.data_operandB == '1);
            end else begin
                case (r_state)
                    StMult: begin
                        r_prod <= w_prod_nx;
                        r_cnt  <= r_cnt + 5'd1;
                    end
                    StDiv: begin
                        r_rem <= w_rem_nx;
                        r_quo <= {r_quo[WIDTH-2:0], ~w_rem_nx[WIDTH]};
                        r_cnt <= r_cnt + 5'd1;
                    end
                    StDone: begin
                        r_rdy <= 1'b1;
                        if (r_is_div) begin
                            r_result <= r_dz ? '0 : w_quo_fix;
                            r_exc    <= r_dz | r_ovf;
                        end else begin
                            r_result <= r_prod[WIDTH:1];
                            r_exc    <= w_mult_ovf;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mdu.data_result    = r_result;
    assign mdu.data_exception = r_exc;
    assign mdu.data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: literal expectations per operation plus a cycle-level reference model.
module tb_multdiv_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 1'b0;

    multdiv_if bus ();

    multdiv_unit dut (
        .clock (clk),
        .reset (rst),
        .mdu   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the signed-integer definitions.
    task automatic model_mul(input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] res, output logic exc);
        longint p;
        p   = longint'($signed(a)) * longint'($signed(b));
        res = p[31:0];
        exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endtask

    task automatic model_div(input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] res, output logic exc);
        int qa;
        int qb;
        qa = $signed(a);
        qb = $signed(b);
        if (qb == 0) begin
            res = 32'd0;
            exc = 1'b1;
        end else if (a == 32'h8000_0000 && qb == -1) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            res = 32'(qa / qb);
            exc = 1'b0;
        end
    endtask

    // Cycle model: which edge owes a ready pulse, and what the held outputs must be.
    int          edge_n = 0;
    int          due = -1;
    logic [31:0] p_res = '0;
    logic        p_exc = 1'b0;
    logic [31:0] held_res = '0;
    logic        held_exc = 1'b0;
    logic        rdy_exp = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            due      = -1;
            rdy_exp  = 1'b0;
            held_res = '0;
            held_exc = 1'b0;
        end else begin
            edge_n++;
            rdy_exp = 1'b0;
            if (bus.ctrl_MULT) begin
                due = edge_n + 17;
                model_mul(bus.data_operandA, bus.data_operandB, p_res, p_exc);
            end else if (bus.ctrl_DIV) begin
                due = edge_n + 33;
                model_div(bus.data_operandA, bus.data_operandB, p_res, p_exc);
            end else if (edge_n == due) begin
                rdy_exp  = 1'b1;
                held_res = p_res;
                held_exc = p_exc;
                due      = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rdy", {31'd0, bus.data_resultRDY}, {31'd0, rdy_exp});
            check("model_result", bus.data_result, held_res);
            check("model_exception", {31'd0, bus.data_exception}, {31'd0, held_exc});
        end
    end

    task automatic launch(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clk);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Returns the edge index (relative to the start edge) of the first ready pulse, 0 if none by 80.
    task automatic wait_rdy(input int offset, output int lat);
        lat = 0;
        for (int k = offset + 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (bus.data_resultRDY) begin
                lat = k;
                break;
            end
        end
    endtask

    typedef struct {
        bit          mul;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          exc;
        int          lat;
    } vec_t;

    vec_t vecs[15] = '{
        '{1'b1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 17},
        '{1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 17},
        '{1'b1, 32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, 17},
        '{1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33},
        '{1'b0, 32'd100,       32'd7,         32'd14,        1'b0, 33},
        '{1'b0, 32'd5,         32'd0,         32'd0,         1'b1, 33},
        '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33},
        '{1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30,        1'b0, 17},
        '{1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33},
        '{1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0, 33},
        '{1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 17},
        '{1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 33},
        '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 17},
        '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 17},
        '{1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 33}
    };

    initial begin
        int lat;
        int rdy_seen;
        bit zero_ok;

        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        #2;
        rst    = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", bus.data_result, 32'd0);
        check("reset_exception", {31'd0, bus.data_exception}, 32'd0);
        check("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            launch(vecs[i].mul, !vecs[i].mul, vecs[i].a, vecs[i].b);
            wait_rdy(0, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_result", i), bus.data_result, vecs[i].res);
            check($sformatf("vec%0d_exception", i), {31'd0, bus.data_exception},
                  {31'd0, vecs[i].exc});
        end

        // MULT aborted by a DIV issued five edges later.
        launch(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (3) @(posedge clk);
        launch(1'b0, 1'b1, 32'd100, 32'd7);
        wait_rdy(5, lat);
        check("abort_latency", 32'(lat), 32'd38);
        check("abort_result", bus.data_result, 32'd14);
        check("abort_exception", {31'd0, bus.data_exception}, 32'd0);

        // Reset in the middle of a DIV.
        launch(1'b0, 1'b1, 32'd9, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_result", bus.data_result, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rdy_seen = 0;
        zero_ok  = 1'b1;
        for (int k = 12; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.data_resultRDY) rdy_seen++;
            if (bus.data_result !== 32'd0 || bus.data_exception !== 1'b0) zero_ok = 1'b0;
        end
        check("midreset_no_rdy", 32'(rdy_seen), 32'd0);
        check("midreset_outputs_zero", {31'd0, zero_ok}, 32'd1);

        // Both start pulses at once: multiply wins.
        launch(1'b1, 1'b1, 32'd6, 32'd2);
        wait_rdy(0, lat);
        check("both_latency", 32'(lat), 32'd17);
        check("both_result", bus.data_result, 32'd12);
        check("both_exception", {31'd0, bus.data_exception}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
